// File: rtl/branch_resolve_unit_pkg.sv
// Shared RV32I control-flow encodings and helpers for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam logic [6:0] op_br   = 7'b1100011;
  localparam logic [6:0] op_jal  = 7'b1101111;
  localparam logic [6:0] op_jalr = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  function automatic logic is_ctrl(input logic [6:0] opcode);
    return (opcode == op_br) || (opcode == op_jal) || (opcode == op_jalr);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Operand-side request and redirect-side result bundle; master drives ops, slave resolves them.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            out_valid;
  logic            out_ready;
  logic            br_en;
  logic [XLEN-1:0] target;
  logic            mispredict;

  modport master (
    output in_valid, opcode, funct3, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, br_en, target, mispredict
  );

  modport slave (
    input  in_valid, opcode, funct3, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready,
    output in_ready, out_valid, br_en, target, mispredict
  );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator; reserved funct3 encodings resolve not-taken.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  branch_funct3_t  i_funct3,
  output logic            o_take
);
  always_comb begin
    o_take = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_take = (i_a == i_b);
      F3_BNE:  o_take = (i_a != i_b);
      F3_BLT:  o_take = ($signed(i_a) <  $signed(i_b));
      F3_BGE:  o_take = ($signed(i_a) >= $signed(i_b));
      F3_BLTU: o_take = (i_a <  i_b);
      F3_BGEU: o_take = (i_a >= i_b);
      default: o_take = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BRANCH/JAL/JALR against the fetch prediction, LATENCY (1|2) cycles accept-to-result.
// in_ready falls combinationally when the pipe is full and out_ready is low; counters saturate.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  branch_resolve_unit_if.slave  bus,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispred_cnt
);
  logic            w_cond, w_is_br, w_is_jal, w_is_jalr, w_is_ctrl, w_br_en, w_accept;
  logic [XLEN-1:0] w_pc_imm, w_rs1_imm, w_pc4;
  logic            w_l_vld, w_l_br_en, w_l_ctrl, w_l_mispred, w_adv_last, w_out_hs;
  logic [XLEN-1:0] w_l_target;
  logic            r_out_vld, r_br_en, r_mispred, r_ctrl;
  logic [XLEN-1:0] r_target;
  logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;

  function automatic logic [XLEN-1:0] f_target(input logic is_jalr, input logic br_en,
                                               input logic [XLEN-1:0] pc_imm, rs1_imm, pc4);
    if (is_jalr) return {rs1_imm[XLEN-1:1], 1'b0};
    return br_en ? pc_imm : pc4;
  endfunction

  function automatic logic f_mispred(input logic br_en, input logic [XLEN-1:0] tgt,
                                     input logic pred_taken, input logic [XLEN-1:0] pred_target);
    return (br_en != pred_taken) | (br_en & (pred_target != tgt));
  endfunction

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .i_a      (bus.rs1),
    .i_b      (bus.rs2),
    .i_funct3 (branch_funct3_t'(bus.funct3)),
    .o_take   (w_cond)
  );

  assign w_is_br    = (bus.opcode == op_br);
  assign w_is_jal   = (bus.opcode == op_jal);
  assign w_is_jalr  = (bus.opcode == op_jalr);
  assign w_is_ctrl  = is_ctrl(bus.opcode);
  assign w_br_en    = w_is_jal | w_is_jalr | (w_is_br & w_cond);
  assign w_pc_imm   = bus.pc + bus.imm;
  assign w_rs1_imm  = bus.rs1 + bus.imm;
  assign w_pc4      = bus.pc + XLEN'(4);
  assign w_accept   = bus.in_valid & bus.in_ready;
  assign w_adv_last = !r_out_vld | bus.out_ready;
  assign w_out_hs   = r_out_vld & bus.out_ready;

  if (XLEN < 8) begin : g_bad_xlen
    $error("branch_resolve_unit: XLEN must be at least 8");
  end

  if (LATENCY == 1) begin : g_lat1
    assign bus.in_ready = !flush & w_adv_last;
    assign w_l_vld      = w_accept;
    assign w_l_br_en    = w_br_en;
    assign w_l_ctrl     = w_is_ctrl;
    assign w_l_target   = f_target(w_is_jalr, w_br_en, w_pc_imm, w_rs1_imm, w_pc4);
    assign w_l_mispred  = f_mispred(w_br_en, w_l_target, bus.pred_taken, bus.pred_target);
  end else if (LATENCY == 2) begin : g_lat2
    logic            r_s1_vld, r_s1_br_en, r_s1_jalr, r_s1_ctrl, r_s1_pred_taken;
    logic [XLEN-1:0] r_s1_pc_imm, r_s1_rs1_imm, r_s1_pc4, r_s1_pred_target;
    logic            w_adv_s1;

    assign w_adv_s1     = !r_s1_vld | w_adv_last;
    assign bus.in_ready = !flush & w_adv_s1;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s1_vld         <= 1'b0;
        r_s1_br_en       <= 1'b0;
        r_s1_jalr        <= 1'b0;
        r_s1_ctrl        <= 1'b0;
        r_s1_pred_taken  <= 1'b0;
        r_s1_pc_imm      <= '0;
        r_s1_rs1_imm     <= '0;
        r_s1_pc4         <= '0;
        r_s1_pred_target <= '0;
      end else begin
        if (flush)         r_s1_vld <= 1'b0;
        else if (w_adv_s1) r_s1_vld <= w_accept;
        if (w_adv_s1 && w_accept) begin
          r_s1_br_en       <= w_br_en;
          r_s1_jalr        <= w_is_jalr;
          r_s1_ctrl        <= w_is_ctrl;
          r_s1_pred_taken  <= bus.pred_taken;
          r_s1_pc_imm      <= w_pc_imm;
          r_s1_rs1_imm     <= w_rs1_imm;
          r_s1_pc4         <= w_pc4;
          r_s1_pred_target <= bus.pred_target;
        end
      end
    end

    assign w_l_vld     = r_s1_vld;
    assign w_l_br_en   = r_s1_br_en;
    assign w_l_ctrl    = r_s1_ctrl;
    assign w_l_target  = f_target(r_s1_jalr, r_s1_br_en, r_s1_pc_imm, r_s1_rs1_imm, r_s1_pc4);
    assign w_l_mispred = f_mispred(r_s1_br_en, w_l_target, r_s1_pred_taken, r_s1_pred_target);
  end else begin : g_bad_latency
    $error("branch_resolve_unit: LATENCY must be 1 or 2");
  end

  // A flush coinciding with an output handshake still retires and counts that result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_vld     <= 1'b0;
      r_br_en       <= 1'b0;
      r_target      <= '0;
      r_mispred     <= 1'b0;
      r_ctrl        <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (flush)           r_out_vld <= 1'b0;
      else if (w_adv_last) r_out_vld <= w_l_vld;
      if (w_adv_last && w_l_vld) begin
        r_br_en   <= w_l_br_en;
        r_target  <= w_l_target;
        r_mispred <= w_l_mispred;
        r_ctrl    <= w_l_ctrl;
      end
      if (w_out_hs && r_ctrl && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_out_hs && r_mispred && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid  = r_out_vld;
  assign bus.br_en      = r_br_en;
  assign bus.target     = r_target;
  assign bus.mispredict = r_mispred;
  assign branch_cnt     = r_branch_cnt;
  assign mispred_cnt    = r_mispred_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: dut 0 = LATENCY 1, dut 1 = LATENCY 2, dut 2 = LATENCY 1 with 2-bit counters.
module tb_branch_resolve_unit;
  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid, out_ready, flush;
  logic [2:0]  in_ready, out_valid, br_en, mispredict;
  logic [31:0] target [3];
  logic [15:0] bcnt [3];
  logic [15:0] mcnt [3];
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm, pred_target;
  logic        pred_taken;
  int          n_chk = 0;
  int          n_fail = 0;
  int          sent, got;

  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 2 : 1;
    localparam int CW  = (g == 2) ? 2 : 16;
    logic [CW-1:0] bc, mc;
    branch_resolve_unit_if #(.XLEN(32)) bus ();
    assign bus.in_valid    = in_valid[g];
    assign bus.out_ready   = out_ready[g];
    assign bus.opcode      = opcode;
    assign bus.funct3      = funct3;
    assign bus.rs1         = rs1;
    assign bus.rs2         = rs2;
    assign bus.pc          = pc;
    assign bus.imm         = imm;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign in_ready[g]     = bus.in_ready;
    assign out_valid[g]    = bus.out_valid;
    assign br_en[g]        = bus.br_en;
    assign mispredict[g]   = bus.mispredict;
    assign target[g]       = bus.target;
    assign bcnt[g]         = 16'(bc);
    assign mcnt[g]         = 16'(mc);
    branch_resolve_unit #(.XLEN(32), .LATENCY(LAT), .CNT_W(CW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush[g]),
      .bus         (bus),
      .branch_cnt  (bc),
      .mispred_cnt (mc)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                        input logic pt, input logic [31:0] ptg);
    opcode = op; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i;
    pred_taken = pt; pred_target = ptg;
  endtask

  task automatic set_jal(input logic [31:0] p, input logic pt);
    set_op(OP_JAL, 3'b000, 32'h0, 32'h0, p, 32'h10, pt, p + 32'h10);
  endtask

  // One op through the LATENCY=1 unit with out_ready high, then let it retire.
  task automatic run0(input string tag, input logic eb, input logic [31:0] et, input logic em);
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid[0]), 32'd1);
    chk({tag, "_br"},  32'(br_en[0]), 32'(eb));
    chk({tag, "_tgt"}, target[0], et);
    chk({tag, "_mis"}, 32'(mispredict[0]), 32'(em));
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = '1; flush = '0;
    set_op(7'h0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();
    chk("rst_vld0", 32'(out_valid[0]), 32'd0);
    chk("rst_vld1", 32'(out_valid[1]), 32'd0);
    chk("rst_br0",  32'(br_en[0]), 32'd0);
    chk("rst_tgt0", target[0], 32'h0);
    chk("rst_mis0", 32'(mispredict[0]), 32'd0);
    chk("rst_bcnt0", 32'(bcnt[0]), 32'd0);
    chk("rst_mcnt0", 32'(mcnt[0]), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy0", 32'(in_ready[0]), 32'd1);

    // LATENCY=1 directed vectors
    set_op(OP_BR, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
    run0("beq", 1'b1, 32'h120, 1'b1);
    chk("beq_bcnt", 32'(bcnt[0]), 32'd1);
    chk("beq_mcnt", 32'(mcnt[0]), 32'd1);
    set_op(OP_BR, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240);
    run0("blt", 1'b1, 32'h240, 1'b0);
    set_op(OP_BR, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0);
    run0("bltu", 1'b0, 32'h204, 1'b0);
    set_op(OP_JALR, 3'b000, 32'h1001, 32'h0, 32'h300, 32'h4, 1'b1, 32'h1004);
    run0("jalr", 1'b1, 32'h1004, 1'b0);
    set_op(OP_BR, 3'b010, 32'd7, 32'd7, 32'h400, 32'h8, 1'b0, 32'h0);
    run0("f3rsv", 1'b0, 32'h404, 1'b0);
    set_op(OP_ALU, 3'b000, 32'd1, 32'd2, 32'h500, 32'h0, 1'b1, 32'h504);
    run0("nonctl", 1'b0, 32'h504, 1'b1);
    set_op(OP_BR, 3'b101, 32'd1, 32'hFFFFFFFF, 32'h600, 32'hFFFFFFF0, 1'b1, 32'h5F0);
    run0("bge", 1'b1, 32'h5F0, 1'b0);
    set_op(OP_JAL, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h0);
    run0("jalwrap", 1'b1, 32'h4, 1'b1);
    set_op(OP_BR, 3'b001, 32'd3, 32'd3, 32'h700, 32'h10, 1'b1, 32'h710);
    run0("bne", 1'b0, 32'h704, 1'b1);
    chk("l1_bcnt", 32'(bcnt[0]), 32'd8);
    chk("l1_mcnt", 32'(mcnt[0]), 32'd4);

    // LATENCY=2 backpressure: fill the pipe, stall, then drain in order
    out_ready[1] = 1'b0;
    set_jal(32'h1000, 1'b1);
    in_valid[1] = 1'b1;
    #1 chk("stall_rdy0", 32'(in_ready[1]), 32'd1);
    tick();
    chk("lat2_notyet", 32'(out_valid[1]), 32'd0);
    set_jal(32'h1100, 1'b1);
    #1 chk("stall_rdy1", 32'(in_ready[1]), 32'd1);
    tick();
    set_jal(32'h1200, 1'b1);
    #1 chk("stall_full", 32'(in_ready[1]), 32'd0);
    chk("stall_vld", 32'(out_valid[1]), 32'd1);
    chk("stall_hold0", target[1], 32'h1010);
    tick();
    chk("stall_hold1", target[1], 32'h1010);
    chk("stall_full2", 32'(in_ready[1]), 32'd0);
    tick();
    chk("stall_hold2", target[1], 32'h1010);
    out_ready[1] = 1'b1;
    sent = 2; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (sent < 4) set_jal(32'h1000 + 32'(sent) * 32'h100, 1'b1);
      in_valid[1] = (sent < 4);
      #1;
      if (out_valid[1]) begin
        chk($sformatf("order%0d", got), target[1], 32'h1010 + 32'(got) * 32'h100);
        got++;
      end
      if (in_valid[1] && in_ready[1]) sent++;
      tick();
    end
    in_valid[1] = 1'b0;
    chk("stall_retired", 32'(got), 32'd4);
    chk("stall_drain", 32'(out_valid[1]), 32'd0);
    chk("stall_bcnt", 32'(bcnt[1]), 32'd4);
    chk("stall_mcnt", 32'(mcnt[1]), 32'd0);

    // Flush with two ops in flight and a third presented
    out_ready[1] = 1'b0;
    set_jal(32'h2000, 1'b0);
    in_valid[1] = 1'b1;
    tick();
    set_jal(32'h2100, 1'b0);
    tick();
    set_jal(32'h2200, 1'b0);
    flush[1] = 1'b1;
    #1 chk("flush_rdy", 32'(in_ready[1]), 32'd0);
    tick();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    chk("flush_vld", 32'(out_valid[1]), 32'd0);
    chk("flush_bcnt", 32'(bcnt[1]), 32'd4);
    chk("flush_mcnt", 32'(mcnt[1]), 32'd0);
    out_ready[1] = 1'b1;
    tick();
    chk("flush_kill", 32'(out_valid[1]), 32'd0);
    chk("flush_bcnt2", 32'(bcnt[1]), 32'd4);

    // Flush in the same cycle as an output handshake
    set_jal(32'h3000, 1'b0);
    in_valid[1] = 1'b1;
    tick();
    set_jal(32'h3100, 1'b0);
    tick();
    in_valid[1] = 1'b0;
    flush[1] = 1'b1;
    #1 chk("fh_vld", 32'(out_valid[1]), 32'd1);
    tick();
    flush[1] = 1'b0;
    chk("fh_bcnt", 32'(bcnt[1]), 32'd5);
    chk("fh_mcnt", 32'(mcnt[1]), 32'd1);
    chk("fh_clr", 32'(out_valid[1]), 32'd0);
    tick();
    chk("fh_kill", 32'(out_valid[1]), 32'd0);

    // 2-bit counters saturate at 3 after five mispredicting JALs
    set_jal(32'h4000, 1'b0);
    in_valid[2] = 1'b1;
    repeat (4) tick();
    chk("sat_mid", 32'(mcnt[2]), 32'd3);
    tick();
    in_valid[2] = 1'b0;
    tick();
    chk("sat_mcnt", 32'(mcnt[2]), 32'd3);
    chk("sat_bcnt", 32'(bcnt[2]), 32'd3);
    chk("sat_drain", 32'(out_valid[2]), 32'd0);
    chk("sat_tgt", target[2], 32'h4010);

    rst_n = 1'b0;
    tick();
    chk("rst2_vld", 32'(out_valid[2]), 32'd0);
    chk("rst2_br",  32'(br_en[2]), 32'd0);
    chk("rst2_tgt", target[2], 32'h0);
    chk("rst2_mis", 32'(mispredict[2]), 32'd0);
    chk("rst2_bcnt", 32'(bcnt[2]), 32'd0);
    chk("rst2_mcnt", 32'(mcnt[2]), 32'd0);
    chk("rst2_bcnt1", 32'(bcnt[1]), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the combinational branch comparator.
- Resolves BRANCH, JAL and JALR: computes taken/not-taken and the target, and checks the result against the fetch-stage prediction.
- Produces a redirect/mispredict indication and keeps saturating performance counters.
- Sits between the execute-stage operand muxes and the fetch redirect logic; valid/ready handshake on both sides.

Parameters:
- XLEN, 32, operand/PC width in bits (≥8).
- LATENCY, 1, pipeline depth from accept to result; legal values 1 or 2.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  kill all in-flight ops.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept op this cycle.
- opcode  in  7  RV32I opcode.
- funct3  in  3  branch condition (branch_funct3_t).
- rs1  in  XLEN  operand a.
- rs2  in  XLEN  operand b.
- pc  in  XLEN  op PC.
- imm  in  XLEN  sign-extended immediate.
- pred_taken  in  1  fetch predicted taken.
- pred_target  in  XLEN  fetch predicted target.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- br_en  out  1  resolved taken.
- target  out  XLEN  resolved next PC.
- mispredict  out  1  redirect required.
- branch_cnt  out  CNT_W  retired control-flow ops.
- mispred_cnt  out  CNT_W  retired mispredicts.

Behaviour:
- Reset (rst_n=0 at posedge): all stage valids=0, out_valid=0, br_en=0, target=0, mispredict=0, both counters=0. Reset mid-operation discards in-flight ops.
- Condition (opcode 1100011):
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011: br_en=0.
- Target and taken by opcode:
  - BRANCH: target = br_en ? pc+imm : pc+4.
  - JAL (1101111): br_en=1, target = pc+imm.
  - JALR (1100111): br_en=1, target = (rs1+imm) & ~1.
  - Any other opcode: br_en=0, target = pc+4.
- All additions are modulo 2^XLEN; wrap-around is silent.
- mispredict = (br_en != pred_taken) | (br_en & pred_target != target).
  - A non-control op with pred_taken=1 therefore mispredicts, with target = pc+4.
- LATENCY=1: result registered; out_valid is asserted the cycle after accept.
- LATENCY=2: stage 1 registers br_en, pc+imm, rs1+imm and the prediction; stage 2 registers target and mispredict. out_valid is asserted 2 cycles after accept.
- Handshake:
  - Accept when in_valid & in_ready.
  - Each stage advances when it is empty or its successor advances; the last stage advances on out_ready.
  - in_ready = !flush & (stage1 empty | stage1 advances). It is combinational from out_ready; no skid buffer.
  - While out_valid=1 & out_ready=0, all outputs hold stable.
  - Full throughput: 1 op/cycle when out_ready=1.
- flush=1 (synchronous): all stage valids clear next cycle and the input is not accepted. Data registers may keep stale values, but out_valid=0.
- Flush and output handshake in the same cycle: the output completes (counted); the remaining stages are killed.
- Counters:
  - Update only on output handshake (out_valid & out_ready).
  - branch_cnt +1 if the op was BRANCH/JAL/JALR.
  - mispred_cnt +1 if mispredict.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Illegal LATENCY must fail elaboration.

Decomposition:
- Package: opcode constants (op_br, op_jal, op_jalr) and branch_funct3_t enum. Reuse the existing rv32i_types package; add an is_ctrl helper function.
- Sub-module: branch_cond_eval (combinational, XLEN-parametrised condition evaluator); instanced once in stage 1.
- Counters stay inline.

Test Plan:
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, pred_taken=0, out_ready=1 → after LATENCY cycles: br_en=1, target=0x120, mispredict=1, branch_cnt=1, mispred_cnt=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → br_en=1. Same operands with BLTU → br_en=0. With pred_taken matching and pred_target correct, mispredict=0.
- JALR rs1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 → target=0x1004 (bit0 cleared), mispredict=0.
- Back-to-back 4 ops with out_ready held 0 for 3 cycles → in_ready drops once the pipe is full, outputs hold stable, all 4 ops retire in order with no loss or duplication.
- flush asserted with 2 ops in flight (LATENCY=2) and in_valid=1 → in_ready=0, out_valid=0 next cycle, counters unchanged.
- CNT_W=2: 5 mispredicting JALs retired → mispred_cnt saturates at 3. Then rst_n=0 for 1 cycle → all outputs and counters return to 0.
